// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field layout, state encoding and constants.
// Used by both the sequential multiplier and the combinational divider.
package fpu_pkg;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

  localparam logic [31:0]      ZERO    = 32'h0000_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fpu_multiply_seq_mul.sv
// Radix-2 shift-add unsigned mantissa multiplier.
// One multiplier bit per step; last flags the final step.
module mant_shift_add_mul #(
  parameter int MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [MANT_W-1:0]     a,
  input  logic [MANT_W-1:0]     b,
  output logic [2*MANT_W-1:0]   acc,
  output logic                  last
);

  logic [MANT_W-1:0] mcand;
  logic [MANT_W-1:0] mplier;
  logic [4:0]        cnt;
  logic [2*MANT_W-1:0] addend;

  assign addend = {{MANT_W{1'b0}}, mcand} << cnt;
  assign last   = step && (cnt == 5'(MANT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0])
        acc <= acc + addend;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
    end
  end

endmodule

// File: rtl/fpu_multiply_seq.sv
// Sequential IEEE 754 single-precision multiplier, truncating.
// FSM owns handshake, exponent and packing; mantissas go to the shift-add core.
module fpu_multiply_seq #(
  parameter int BIAS   = 127,
  parameter int MANT_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [31:0] product,
  output logic        valid,
  output logic        busy,
  output logic        ovf,
  output logic        unf
);
  import fpu_pkg::*;

  state_t state;

  logic              sign;
  logic signed [9:0] esum;
  logic signed [9:0] esum_n;
  logic signed [9:0] e_norm;
  logic              load;
  logic              step;
  logic              last;
  logic              is_zero;
  logic [2*MANT_W-1:0] acc;
  logic [FRAC_W-1:0]   frac;

  assign load    = (state == IDLE) && start;
  assign step    = (state == CALC);
  assign is_zero = (multiplicand == ZERO) || (multiplier == ZERO);

  assign esum_n = 10'(multiplicand[EXP_MSB:EXP_LSB])
                + 10'(multiplier[EXP_MSB:EXP_LSB])
                - 10'(BIAS);

  assign e_norm = esum + 10'(acc[2*MANT_W-1]);
  assign frac   = acc[2*MANT_W-1] ? acc[46:24] : acc[45:23];

  mant_shift_add_mul #(
    .MANT_W (MANT_W)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    ({1'b1, multiplicand[FRAC_MSB:FRAC_LSB]}),
    .b    ({1'b1, multiplier[FRAC_MSB:FRAC_LSB]}),
    .acc  (acc),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sign    <= 1'b0;
      esum    <= '0;
      product <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            sign <= multiplicand[SIGN_BIT] ^ multiplier[SIGN_BIT];
            esum <= esum_n;
            busy <= 1'b1;
            if (is_zero) begin
              // Only +0 bit patterns short-circuit; -0 runs the datapath.
              product <= ZERO;
              ovf     <= 1'b0;
              unf     <= 1'b0;
              valid   <= 1'b1;
              state   <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (last)
            state <= NORM;
        end
        NORM: begin
          if (e_norm >= 10'sd255) begin
            product <= {sign, EXP_MAX, {FRAC_W{1'b0}}};
            ovf     <= 1'b1;
            unf     <= 1'b0;
          end else if (e_norm <= 10'sd0) begin
            product <= {sign, 31'b0};
            ovf     <= 1'b0;
            unf     <= 1'b1;
          end else begin
            product <= {sign, e_norm[EXP_W-1:0], frac};
            ovf     <= 1'b0;
            unf     <= 1'b0;
          end
          valid <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_multiply_seq.sv
// Directed self-checking bench for fpu_multiply_seq.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_fpu_multiply_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] product;
  logic        valid;
  logic        busy;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fpu_multiply_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .valid        (valid),
    .busy         (busy),
    .ovf          (ovf),
    .unf          (unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and check latency, result, flags and handshake.
  task automatic run(input string tag, input logic [31:0] a,
                     input logic [31:0] b, input int lat,
                     input logic [31:0] exp_p, input logic exp_o,
                     input logic exp_u);
    int n;
    logic busy_ok;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start   = 1'b0;
    n       = 1;
    busy_ok = busy;
    while (!valid && n < 40) begin
      tick();
      n++;
      if (!busy) busy_ok = 1'b0;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_prod"}, product, exp_p);
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
    chk({tag, "_unf"}, 32'(unf), 32'(exp_u));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    tick();
    chk({tag, "_vpulse"}, 32'(valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, product, exp_p);
  endtask

  initial begin
    int n;
    logic seen;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    chk("rst_prod", product, 32'h0);
    chk("rst_flags", {28'b0, valid, busy, ovf, unf}, 32'h0);
    rst = 1'b0;
    tick();

    run("mul_2x3", 32'h40000000, 32'h40400000, 26, 32'h40C00000, 0, 0);
    run("mul_1p5sq", 32'h3FC00000, 32'h3FC00000, 26, 32'h40100000, 0, 0);
    run("mul_neg", 32'hC0000000, 32'h3F000000, 26, 32'hBF800000, 0, 0);
    run("zero_a", 32'h00000000, 32'h40400000, 1, 32'h00000000, 0, 0);
    run("ovf", 32'h7F000000, 32'h7F000000, 26, 32'h7F800000, 1, 0);
    run("unf", 32'h00800000, 32'h00800000, 26, 32'h00000000, 0, 1);
    run("zero_b", 32'hC0400000, 32'h00000000, 1, 32'h00000000, 0, 0);
    run("ovf_e255", 32'h7F000000, 32'h40000000, 26, 32'h7F800000, 1, 0);
    run("e254", 32'h7F000000, 32'h3F800000, 26, 32'h7F000000, 0, 0);
    run("negzero", 32'h80000000, 32'h40000000, 26, 32'h80800000, 0, 0);
    run("novf_neg", 32'hFF000000, 32'h7F000000, 26, 32'hFF800000, 1, 0);

    // Start and new operands mid-CALC must not disturb the in-flight op.
    multiplicand = 32'h40000000;
    multiplier   = 32'h40400000;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start        = 1'b1;
    multiplicand = 32'h3F800000;
    multiplier   = 32'h3F800000;
    repeat (3) tick();
    start = 1'b0;
    n = 9;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    chk("busy_start_lat", n, 26);
    chk("busy_start_prod", product, 32'h40C00000);
    tick();

    // Back-to-back with start held high.
    multiplicand = 32'h40000000;
    multiplier   = 32'h3F800000;
    start        = 1'b1;
    n = 0;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_first", product, 32'h40000000);
    n = 0;
    tick();
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_period", n + 1, 27);
    start = 1'b0;
    tick();
    tick();

    // Abort with reset at CALC cycle 10.
    multiplicand = 32'h3FC00000;
    multiplier   = 32'h40400000;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("abort_prod", product, 32'h0);
    chk("abort_flags", {28'b0, valid, busy, ovf, unf}, 32'h0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (valid) seen = 1'b1;
    end
    chk("abort_novalid", 32'(seen), 32'd0);

    run("after_rst", 32'h3FC00000, 32'h40400000, 26, 32'h40900000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
